// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Data-memory load engine. Takes a load request (address, funct3)
//             from execute, performs one word-aligned read over a ready/valid
//             memory handshake, then extracts and sign/zero-extends the
//             addressed byte/half/word for the writeback mux. Holds the
//             pipeline (stall) for the duration of the load.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             ld_req/ld_addr/ld_funct3 - load request from execute
//             stall                 - hold PC/pipeline (combinational)
//             rd_mem/rd_mem_valid   - extended load data + update pulse
//             err                   - misaligned/illegal/timeout pulse
//             mem_req/mem_addr/mem_ready - memory request channel
//             mem_rvalid/mem_rdata  - memory response channel
//  Revision : 1.0 - initial release
// ============================================================================
module load_unit #(
   parameter int REG_LEN     = 32,
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld_req,
   input  logic [REG_LEN-1:0] ld_addr,
   input  logic [2:0]         ld_funct3,
   output logic               stall,
   output logic [REG_LEN-1:0] rd_mem,
   output logic               rd_mem_valid,
   output logic               err,
   output logic               mem_req,
   output logic [REG_LEN-1:0] mem_addr,
   input  logic               mem_ready,
   input  logic               mem_rvalid,
   input  logic [REG_LEN-1:0] mem_rdata
);

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_req  = 3'd1;
   localparam logic [2:0] c_st_wait = 3'd2;
   localparam logic [2:0] c_st_done = 3'd3;
   localparam logic [2:0] c_st_err  = 3'd4;

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

   logic [2:0]         state_q, state_d;
   logic               mem_req_q, mem_req_d;
   logic [REG_LEN-1:0] mem_addr_q, mem_addr_d;
   logic [REG_LEN-1:0] rd_mem_q, rd_mem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         off_q, off_d;
   logic [2:0]         f3_q, f3_d;

   logic               w_legal;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [REG_LEN-1:0] w_ext;

   // Legal funct3 values are LB/LH/LW/LBU/LHU; halves need addr[0]=0 and
   // words need addr[1:0]=0.
   always_comb begin
      w_legal = 1'b0;
      case (ld_funct3)
         3'b000, 3'b100: w_legal = 1'b1;
         3'b001, 3'b101: w_legal = ~ld_addr[0];
         3'b010:         w_legal = (ld_addr[1:0] == 2'b00);
         default:        w_legal = 1'b0;
      endcase
   end

   // Lane extraction uses the offset/funct3 latched at request time, since
   // ld_addr may change once the core is released.
   always_comb begin
      w_byte = mem_rdata[7:0];
      case (off_q)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_ext  = mem_rdata;
      case (f3_q)
         3'b000:  w_ext = {{(REG_LEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_ext = {{(REG_LEN-8){1'b0}}, w_byte};
         3'b001:  w_ext = {{(REG_LEN-16){w_half[15]}}, w_half};
         3'b101:  w_ext = {{(REG_LEN-16){1'b0}}, w_half};
         default: w_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      rd_mem_d   = rd_mem_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      f3_d       = f3_q;
      case (state_q)
         c_st_idle: begin
            if (ld_req) begin
               if (w_legal) begin
                  off_d      = ld_addr[1:0];
                  f3_d       = ld_funct3;
                  mem_addr_d = {ld_addr[REG_LEN-1:2], 2'b00};
                  mem_req_d  = 1'b1;
                  cnt_d      = '0;
                  state_d    = c_st_req;
               end else begin
                  state_d = c_st_err;
               end
            end
         end
         c_st_req: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = c_st_wait;
            end else if (cnt_q == c_cnt_last) begin
               mem_req_d = 1'b0;
               state_d   = c_st_err;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         c_st_wait: begin
            if (mem_rvalid) begin
               rd_mem_d = w_ext;
               state_d  = c_st_done;
            end else if (cnt_q == c_cnt_last) begin
               state_d = c_st_err;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         c_st_done: state_d = c_st_idle;
         c_st_err:  state_d = c_st_idle;
         default: begin
            mem_req_d = 1'b0;
            state_d   = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= c_st_idle;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         rd_mem_q   <= '0;
         cnt_q      <= '0;
         off_q      <= 2'd0;
         f3_q       <= 3'd0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         rd_mem_q   <= rd_mem_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
      end
   end

   // Stall drops in DONE so the core advances in the cycle rd_mem is valid.
   assign stall        = ((state_q == c_st_idle) && ld_req) ||
                         (state_q == c_st_req) || (state_q == c_st_wait) ||
                         (state_q == c_st_err);
   assign rd_mem_valid = (state_q == c_st_done);
   assign err          = (state_q == c_st_err);
   assign rd_mem       = rd_mem_q;
   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Directed self-checking bench for load_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [2:0]  ld_funct3 = '0;
   logic        stall;
   logic [31:0] rd_mem;
   logic        rd_mem_valid;
   logic        err;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;

   int lat, n_stall, n_req, n_valid, n_err, n_wait;
   bit addr_ok;

   always #5 clk = ~clk;

   load_unit #(.REG_LEN(32), .TIMEOUT_CYC(255), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr),
      .ld_funct3(ld_funct3), .stall(stall), .rd_mem(rd_mem),
      .rd_mem_valid(rd_mem_valid), .err(err), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // Drives one load from an IDLE negedge and records what it observes.
   // mem_ready rises rdy_wait negedges after the request; rvalid pulses
   // rv_wait negedges into WAIT (rv_wait<0: never). Ends one cycle after
   // the done/err pulse, back at an IDLE negedge.
   task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input int rdy_wait,
                           input int rv_wait, output int o_lat,
                           output int o_stall, output int o_req,
                           output int o_valid, output int o_err,
                           output int o_wait, output bit o_addr_ok);
      int acc;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      ld_req = 1'b1; ld_addr = addr; ld_funct3 = f3;
      mem_ready = (rdy_wait == 0); mem_rvalid = 1'b0; mem_rdata = rdata;
      o_lat = -1; o_req = 0; o_valid = 0; o_err = 0; o_wait = 0;
      o_addr_ok = 1'b1; acc = -1;
      #1;
      o_stall = stall ? 1 : 0;
      for (int k = 1; k <= 600 && o_lat < 0; k++) begin
         @(negedge clk);
         if (stall) o_stall++;
         if (rd_mem_valid) o_valid++;
         if (err) o_err++;
         if (mem_req) begin
            o_req++;
            if (mem_addr !== exp_addr) o_addr_ok = 1'b0;
         end
         if (rd_mem_valid || err) begin
            o_lat = k;
            ld_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
         end else begin
            if (acc >= 0) o_wait++;
            mem_ready  = (k >= rdy_wait);
            mem_rvalid = (rv_wait > 0) && (acc >= 0) && (k == acc + rv_wait);
            if (mem_req && mem_ready && acc < 0) acc = k;
         end
      end
      ld_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=00000000", mem_addr); end
      total++; if (rd_mem !== 32'h0) begin bad++; $display("FAIL rst_rd_mem got=%h want=00000000", rd_mem); end
      total++; if (rd_mem_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_mem_valid got=%b want=0", rd_mem_valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw_basic();
      run_load(32'h0000_1004, 3'b010, 32'hDEAD_BEEF, 0, 1,
               lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
      total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
      total++; if (n_stall !== 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=3", n_stall); end
      total++; if (n_valid !== 1) begin bad++; $display("FAIL lw_valid_pulses got=%0d want=1", n_valid); end
      total++; if (n_req !== 1 || !addr_ok) begin bad++; $display("FAIL lw_mem_req got=%0d addr_ok=%0d want=1 addr_ok=1", n_req, addr_ok); end
      total++; if (mem_addr !== 32'h0000_1004) begin bad++; $display("FAIL lw_mem_addr got=%h want=00001004", mem_addr); end
      total++; if (rd_mem !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rd_mem got=%h want=deadbeef", rd_mem); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] addrs [7];
      logic [2:0]  f3s [7];
      logic [31:0] exps [7];
      addrs = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2003, 32'h2002, 32'h2000};
      f3s   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
      exps  = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
      for (int i = 0; i < 7; i++) begin
         run_load(addrs[i], f3s[i], 32'h80FF_7F01, 0, 1,
                  lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
         total++;
         if (rd_mem !== exps[i] || n_valid !== 1 || !addr_ok) begin
            bad++;
            $display("FAIL lane_%0d got=%h valid=%0d addr_ok=%0d want=%h valid=1 addr_ok=1",
                     i, rd_mem, n_valid, addr_ok, exps[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3];
      logic [2:0]  f3s [3];
      addrs = '{32'h1002, 32'h1001, 32'h1000};
      f3s   = '{3'b010, 3'b001, 3'b011};
      for (int i = 0; i < 3; i++) begin
         run_load(addrs[i], f3s[i], 32'h1111_2222, 0, 1,
                  lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
         total++;
         if (n_err !== 1 || lat !== 1 || n_req !== 0 || n_valid !== 0 || n_stall !== 2) begin
            bad++;
            $display("FAIL err_%0d got err=%0d lat=%0d req=%0d valid=%0d stall=%0d want 1/1/0/0/2",
                     i, n_err, lat, n_req, n_valid, n_stall);
         end
         total++;
         if (rd_mem !== 32'h0000_7F01) begin bad++; $display("FAIL err_%0d_rd_mem got=%h want=00007f01", i, rd_mem); end
      end
   endtask

   task automatic test_backpressure();
      run_load(32'h0000_5008, 3'b010, 32'h0BAD_F00D, 5, 4,
               lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
      total++; if (n_req !== 5 || !addr_ok) begin bad++; $display("FAIL bp_mem_req got=%0d addr_ok=%0d want=5 addr_ok=1", n_req, addr_ok); end
      total++; if (lat !== 10) begin bad++; $display("FAIL bp_latency got=%0d want=10", lat); end
      total++; if (n_stall !== 10) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=10", n_stall); end
      total++; if (n_valid !== 1 || n_err !== 0) begin bad++; $display("FAIL bp_pulses got valid=%0d err=%0d want 1/0", n_valid, n_err); end
      total++; if (rd_mem !== 32'h0BAD_F00D) begin bad++; $display("FAIL bp_rd_mem got=%h want=0badf00d", rd_mem); end
   endtask

   task automatic test_timeout();
      run_load(32'h0000_6000, 3'b010, 32'h5555_AAAA, 0, -1,
               lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
      total++; if (n_err !== 1 || n_valid !== 0) begin bad++; $display("FAIL to_pulses got err=%0d valid=%0d want 1/0", n_err, n_valid); end
      total++; if (n_wait !== 255) begin bad++; $display("FAIL to_wait_cycles got=%0d want=255", n_wait); end
      total++; if (lat !== 257) begin bad++; $display("FAIL to_latency got=%0d want=257", lat); end
      total++; if (rd_mem !== 32'h0BAD_F00D) begin bad++; $display("FAIL to_rd_mem got=%h want=0badf00d", rd_mem); end
      // Late response arriving while idle must be dropped.
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      total++;
      if (rd_mem_valid !== 1'b0 || stall !== 1'b0 || rd_mem !== 32'h0BAD_F00D) begin
         bad++;
         $display("FAIL late_rvalid got valid=%b stall=%b rd_mem=%h want 0/0/0badf00d", rd_mem_valid, stall, rd_mem);
      end
      @(negedge clk);
      run_load(32'h0000_3000, 3'b010, 32'hCAFE_F00D, 0, 1,
               lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
      total++;
      if (rd_mem !== 32'hCAFE_F00D || lat !== 3) begin
         bad++;
         $display("FAIL post_to_lw got=%h lat=%0d want=cafef00d lat=3", rd_mem, lat);
      end
   endtask

   task automatic test_reset_mid();
      ld_req = 1'b1; ld_addr = 32'h4001; ld_funct3 = 3'b000;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0000_9A00;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req_state got=%b want=1", mem_req); end
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL mid_wait_state got req=%b stall=%b want 0/1", mem_req, stall); end
      #2;
      rst_n = 1'b0; ld_req = 1'b0; mem_ready = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || rd_mem !== 32'h0 ||
          rd_mem_valid !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got req=%b addr=%h rd=%h valid=%b err=%b stall=%b want all zero",
                  mem_req, mem_addr, rd_mem, rd_mem_valid, err, stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_load(32'h0000_4001, 3'b000, 32'h0000_9A00, 0, 1,
               lat, n_stall, n_req, n_valid, n_err, n_wait, addr_ok);
      total++;
      if (rd_mem !== 32'hFFFF_FF9A || lat !== 3 || !addr_ok) begin
         bad++;
         $display("FAIL mid_post_lb got=%h lat=%0d addr_ok=%0d want=ffffff9a lat=3 addr_ok=1", rd_mem, lat, addr_ok);
      end
   endtask

   initial begin
      test_reset();
      test_lw_basic();
      test_byte_lanes();
      test_errors();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_unit.md
Name: load_unit

Overview:
- Data-memory load engine of the core; sits directly upstream of the writeback mux and drives its memory-data input (rd_mem).
- Accepts a load request (address, funct3) from execute and performs a word-aligned read over a ready/valid memory handshake.
- Extracts, sign- or zero-extends the addressed byte/half/word and stalls the core for the duration of the load.

Parameters:
REG_LEN, 32, data/address width (fixed 32 for RV32I)
TIMEOUT_CYC, 255, max cycles spent in REQ+WAIT before load is abandoned with err
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_req  in  1  load requested by execute stage (level, held while stall=1)
ld_addr  in  REG_LEN  effective byte address from ALU
ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
stall  out  1  hold PC/pipeline (combinational)
rd_mem  out  REG_LEN  extended load data to writeback mux (registered, holds)
rd_mem_valid  out  1  one-cycle pulse: rd_mem updated this cycle
err  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
mem_req  out  1  read request to data memory (registered)
mem_addr  out  REG_LEN  word address, bits[1:0]=00 (registered)
mem_ready  in  1  memory accepts request when mem_req&mem_ready
mem_rvalid  in  1  read data valid
mem_rdata  in  REG_LEN  read data word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mem_req=0, mem_addr=0, rd_mem=0, rd_mem_valid=0, err=0, counter=0. Reset mid-load abandons the transaction; mem_req drops immediately.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - With ld_req=1 and a legal, aligned access: latch offset=ld_addr[1:0] and funct3; mem_addr<={ld_addr[31:2],2'b00}; mem_req<=1; go to REQ.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: no memory access; go to ERR.
- REQ: hold mem_req and mem_addr until an edge with mem_ready=1. On that edge mem_req<=0, counter cleared, go to WAIT.
- WAIT: on the first edge with mem_rvalid=1, rd_mem<=extract(mem_rdata), go to DONE.
- DONE: rd_mem_valid=1 for exactly this cycle; go to IDLE. ld_req is ignored in DONE and sampled fresh next cycle.
- ERR: err=1 for exactly this cycle; rd_mem unchanged; go to IDLE.
- Timeout: counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYC-1 without progress: mem_req<=0, go to ERR.
- mem_rvalid is ignored in IDLE, REQ, DONE and ERR; stale responses are dropped.
- stall = (state==IDLE & ld_req) | state==REQ | state==WAIT | state==ERR. It is 0 in DONE so the core advances in the same cycle rd_mem is valid.
- Minimum latency: ld_req to rd_mem_valid is 3 cycles (IDLE→REQ with mem_ready=1, WAIT with mem_rvalid=1 next cycle, DONE).
- Extraction:
  - LB/LBU: byte mem_rdata[8*off+7:8*off], sign- or zero-extended to 32.
  - LH/LHU: half mem_rdata[16*off[1]+15:16*off[1]], sign- or zero-extended.
  - LW: whole word.
- rd_mem holds its last value across idle cycles, errors and new requests until the next DONE.

Test Plan:
- LW at 0x0000_1004, mem_ready=1 immediately, rdata=0xDEADBEEF one cycle later → mem_addr=0x1004, rd_mem=0xDEADBEEF, rd_mem_valid pulses 3 cycles after ld_req, stall high for exactly 3 cycles.
- Byte lanes: rdata=0x80FF7F01; LB at offsets 0/1/2/3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU at offset 3 → 0x00000080; LH offset 2 → 0xFFFF80FF; LHU offset 0 → 0x00007F01.
- Misaligned LW at 0x1002, then LH at 0x1001, then funct3=011 → err pulse each, mem_req never asserts, rd_mem unchanged.
- Backpressure: mem_ready low for 5 cycles, rvalid 4 cycles after accept → mem_req/mem_addr stable throughout, single rd_mem_valid, stall deasserts only in DONE.
- Timeout: mem_rvalid never asserted → err pulses after TIMEOUT_CYC cycles, state returns to IDLE; a late rvalid in IDLE is ignored and a following LW completes normally.
- rst_n pulled low while in WAIT → all outputs at reset values immediately; after release, a new LB completes with correct data.
